// File: rtl/servo_pkg.sv
// Shared constants and helpers for the servo PWM bank.
package servo_pkg;

    localparam int unsigned DEF_PERIOD_CYC = 2000000;
    localparam int unsigned DEF_MIN_CYC    = 100000;
    localparam int unsigned DEF_MAX_CYC    = 200000;
    localparam int unsigned DEF_STEP_CYC   = 1000;

    localparam int unsigned CLAMP_W = 64;

    // Saturate x into [lo, hi]; callers widen to CLAMP_W and narrow the result back.
    function automatic logic [CLAMP_W-1:0] clamp(input logic [CLAMP_W-1:0] x,
                                                 input logic [CLAMP_W-1:0] lo,
                                                 input logic [CLAMP_W-1:0] hi);
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo channel: clamped target, frame-synchronous active width, pulse compare.
module servo_channel
    import servo_pkg::*;
#(
    parameter int unsigned W        = 32,
    parameter int unsigned MIN_CYC  = DEF_MIN_CYC,
    parameter int unsigned MAX_CYC  = DEF_MAX_CYC,
    parameter int unsigned STEP_CYC = DEF_STEP_CYC
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         boundary,
    input  logic         wr_hit,
    input  logic [W-1:0] wr_data,
    input  logic         enable,
    input  logic         ramp,
    input  logic [W-1:0] nxt_cnt,
    output logic         pwm,
    output logic         busy
);

    localparam logic [W-1:0] MIN_W    = W'(MIN_CYC);
    localparam logic [W-1:0] MAX_W    = W'(MAX_CYC);
    localparam logic [W-1:0] STEP_W   = W'(STEP_CYC);
    localparam logic [W-1:0] CENTER_W = W'((MIN_CYC + MAX_CYC) / 2);

    logic [W-1:0] tgt, cur, nxt_tgt, nxt_cur;
    logic         en_lat, ramp_lat, nxt_en, nxt_ramp;

    // Boundary update reads the pre-write tgt; a same-cycle write only lands in nxt_tgt.
    always_comb begin
        nxt_tgt  = tgt;
        nxt_cur  = cur;
        nxt_en   = en_lat;
        nxt_ramp = ramp_lat;
        if (wr_hit) begin
            nxt_tgt = W'(clamp(CLAMP_W'(wr_data), CLAMP_W'(MIN_W), CLAMP_W'(MAX_W)));
        end
        if (boundary) begin
            nxt_en   = enable;
            nxt_ramp = ramp;
            if (!nxt_ramp) begin
                nxt_cur = tgt;
            end else if (tgt > cur) begin
                nxt_cur = ((tgt - cur) <= STEP_W) ? tgt : cur + STEP_W;
            end else begin
                nxt_cur = ((cur - tgt) <= STEP_W) ? tgt : cur - STEP_W;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tgt      <= CENTER_W;
            cur      <= CENTER_W;
            en_lat   <= 1'b0;
            ramp_lat <= 1'b0;
            pwm      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            tgt      <= nxt_tgt;
            cur      <= nxt_cur;
            en_lat   <= nxt_en;
            ramp_lat <= nxt_ramp;
            pwm      <= nxt_en && (nxt_cnt < nxt_cur);
            busy     <= (nxt_cur != nxt_tgt);
        end
    end

endmodule

// File: rtl/servo_pwm_bank.sv
// Multi-channel servo PWM generator sharing one frame counter.
module servo_pwm_bank
    import servo_pkg::*;
#(
    parameter int unsigned NCH        = 5,
    parameter int unsigned W          = 32,
    parameter int unsigned PERIOD_CYC = DEF_PERIOD_CYC,
    parameter int unsigned MIN_CYC    = DEF_MIN_CYC,
    parameter int unsigned MAX_CYC    = DEF_MAX_CYC,
    parameter int unsigned STEP_CYC   = DEF_STEP_CYC
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [ch_idx_w(NCH)-1:0]   wr_ch,
    input  logic [W-1:0]               wr_data,
    input  logic [NCH-1:0]             enable,
    input  logic [NCH-1:0]             ramp,
    output logic [NCH-1:0]             pwm,
    output logic [NCH-1:0]             busy,
    output logic                       frame_start
);

    localparam int unsigned  CHW    = ch_idx_w(NCH);
    localparam logic [W-1:0] LAST_W = W'(PERIOD_CYC - 1);

    logic [W-1:0] cnt, nxt_cnt;
    logic         boundary;

    always_comb begin
        boundary = (cnt == LAST_W);
        nxt_cnt  = boundary ? '0 : cnt + W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt         <= '0;
            frame_start <= 1'b1;
        end else begin
            cnt         <= nxt_cnt;
            frame_start <= boundary;
        end
    end

    // Indices >= NCH match no channel, so out-of-range writes drop naturally.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic wr_hit;
        assign wr_hit = wr_en && (wr_ch == CHW'(i));

        servo_channel #(
            .W        (W),
            .MIN_CYC  (MIN_CYC),
            .MAX_CYC  (MAX_CYC),
            .STEP_CYC (STEP_CYC)
        ) u_ch (
            .clock    (clock),
            .reset    (reset),
            .boundary (boundary),
            .wr_hit   (wr_hit),
            .wr_data  (wr_data),
            .enable   (enable[i]),
            .ramp     (ramp[i]),
            .nxt_cnt  (nxt_cnt),
            .pwm      (pwm[i]),
            .busy     (busy[i])
        );
    end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Self-checking bench for servo_pwm_bank: per-cycle reference model plus per-frame width table.
module tb_servo_pwm_bank;

    localparam int NCH    = 3;
    localparam int PERIOD = 100;
    localparam int MINC   = 10;
    localparam int MAXC   = 20;
    localparam int STEP   = 3;
    localparam int CENTER = 15;

    logic        clock = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [31:0] wr_data;
    logic [2:0]  enable;
    logic [2:0]  ramp;
    logic [2:0]  pwm;
    logic [2:0]  busy;
    logic        frame_start;

    servo_pwm_bank #(
        .NCH(NCH), .W(32), .PERIOD_CYC(PERIOD),
        .MIN_CYC(MINC), .MAX_CYC(MAXC), .STEP_CYC(STEP)
    ) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_data(wr_data), .enable(enable), .ramp(ramp),
        .pwm(pwm), .busy(busy), .frame_start(frame_start)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference state, frame-level view of each channel.
    int m_cnt;
    int m_tgt [NCH];
    int m_cur [NCH];
    bit m_en  [NCH];
    logic [6:0] m_exp;

    typedef struct {
        logic [2:0] en;
        logic [2:0] rmp;
        int         wr_step;
        logic [1:0] ch;
        int         data;
        int         w0;
        int         w1;
        int         w2;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    function automatic int clampi(input int x);
        if (x < MINC) return MINC;
        if (x > MAXC) return MAXC;
        return x;
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_cnt = 0;
            for (int i = 0; i < NCH; i++) begin
                m_tgt[i] = CENTER;
                m_cur[i] = CENTER;
                m_en[i]  = 1'b0;
            end
        end else begin
            if (m_cnt == PERIOD - 1) begin
                for (int i = 0; i < NCH; i++) begin
                    int d;
                    d = m_tgt[i] - m_cur[i];
                    if (!ramp[i] || (d <= STEP && d >= -STEP)) m_cur[i] = m_tgt[i];
                    else m_cur[i] = m_cur[i] + ((d > 0) ? STEP : -STEP);
                    m_en[i] = enable[i];
                end
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
            if (wr_en && wr_ch < NCH) m_tgt[wr_ch] = clampi(int'(wr_data));
        end
        for (int i = 0; i < NCH; i++) begin
            m_exp[i]     = !reset && m_en[i] && (m_cnt < m_cur[i]);
            m_exp[3 + i] = !reset && (m_cur[i] != m_tgt[i]);
        end
        m_exp[6] = (m_cnt == 0);
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
        check("cycle{fs,busy,pwm}", int'({frame_start, busy, pwm}), int'(m_exp));
    endtask

    // Runs 100 cycles starting from the cnt==PERIOD-1 cycle; counts pulse cycles of cnt 0..99.
    task automatic run_frame(input int idx, input vec_t v);
        int acc [NCH];
        enable = v.en;
        ramp   = v.rmp;
        for (int k = 0; k < NCH; k++) acc[k] = 0;
        for (int j = 0; j < PERIOD; j++) begin
            wr_en   = (j == v.wr_step);
            wr_ch   = v.ch;
            wr_data = 32'(v.data);
            cycle();
            for (int k = 0; k < NCH; k++) acc[k] += int'(pwm[k]);
        end
        wr_en = 1'b0;
        check($sformatf("width ch0 rec%0d", idx), acc[0], v.w0);
        check($sformatf("width ch1 rec%0d", idx), acc[1], v.w1);
        check($sformatf("width ch2 rec%0d", idx), acc[2], v.w2);
    endtask

    // From reset held at cnt 0: release and run to cnt 99, expecting no pulses.
    task automatic reset_sequence(input string tag);
        int acc;
        reset = 1'b1;
        cycle();
        cycle();
        check({tag, " reset pwm"}, int'(pwm), 0);
        check({tag, " reset busy"}, int'(busy), 0);
        check({tag, " reset frame_start"}, int'(frame_start), 1);
        reset = 1'b0;
        acc = 0;
        for (int j = 0; j < PERIOD - 1; j++) begin
            cycle();
            acc += int'(pwm != 3'b000);
            if (j == PERIOD - 2) check({tag, " frame_start low at cnt99"}, int'(frame_start), 0);
        end
        check({tag, " first frame pulses"}, acc, 0);
    endtask

    initial begin
        vec_t v;
        //            en      ramp    step ch  data  w0  w1  w2
        vecs[0]  = '{3'b001, 3'b000, 50, 2'd0, 15, 15,  0,  0};
        vecs[1]  = '{3'b001, 3'b000, -1, 2'd0,  0, 15,  0,  0};
        vecs[2]  = '{3'b010, 3'b010, 50, 2'd1, 20,  0, 15,  0};
        vecs[3]  = '{3'b010, 3'b010, -1, 2'd0,  0,  0, 18,  0};
        vecs[4]  = '{3'b010, 3'b010, -1, 2'd0,  0,  0, 20,  0};
        vecs[5]  = '{3'b100, 3'b000, 50, 2'd2,  5,  0,  0, 15};
        vecs[6]  = '{3'b100, 3'b000, 50, 2'd2, 99,  0,  0, 10};
        vecs[7]  = '{3'b100, 3'b000, 50, 2'd3, 11,  0,  0, 20};
        vecs[8]  = '{3'b111, 3'b000, -1, 2'd0,  0, 15, 20, 20};
        vecs[9]  = '{3'b111, 3'b111, 50, 2'd0, 10, 15, 20, 20};
        vecs[10] = '{3'b111, 3'b111, -1, 2'd0,  0, 12, 20, 20};
        vecs[11] = '{3'b111, 3'b111, -1, 2'd0,  0, 10, 20, 20};
        vecs[12] = '{3'b000, 3'b001, 50, 2'd0, 20,  0,  0,  0};
        vecs[13] = '{3'b000, 3'b001, -1, 2'd0,  0,  0,  0,  0};
        vecs[14] = '{3'b001, 3'b001, -1, 2'd0,  0, 16,  0,  0};
        vecs[15] = '{3'b001, 3'b000, -1, 2'd0,  0, 20,  0,  0};
        vecs[16] = '{3'b001, 3'b000,  0, 2'd0, 12, 20,  0,  0};
        vecs[17] = '{3'b001, 3'b000, -1, 2'd0,  0, 12,  0,  0};

        wr_en = 1'b0; wr_ch = 2'd0; wr_data = 32'd0;
        enable = 3'b000; ramp = 3'b000;
        reset_sequence("init");

        for (int r = 0; r < 18; r++) run_frame(r, vecs[r]);

        // Random writes: the per-cycle model checks every cycle of these frames.
        for (int r = 0; r < 6; r++) begin
            enable = 3'($urandom_range(0, 7));
            ramp   = 3'($urandom_range(0, 7));
            for (int j = 0; j < PERIOD; j++) begin
                wr_en   = ($urandom_range(0, 15) == 0);
                wr_ch   = 2'($urandom_range(0, 3));
                wr_data = 32'($urandom_range(0, 40));
                cycle();
            end
            wr_en = 1'b0;
        end

        // Settle ch0 to width 12, then assert reset mid-pulse at cnt 5.
        v = '{3'b001, 3'b000, 0, 2'd0, 12, 0, 0, 0};
        v.w0 = m_cur[0] == 0 ? 0 : (m_en[0] ? m_cur[0] : 0);
        enable = 3'b001; ramp = 3'b000;
        wr_en = 1'b1; wr_ch = 2'd0; wr_data = 32'd12;
        cycle();
        wr_en = 1'b0;
        for (int j = 1; j < PERIOD; j++) cycle();
        for (int j = 0; j < 6; j++) cycle();
        check("pre-reset pwm0 at cnt5", int'(pwm[0]), 1);
        reset = 1'b1;
        cycle();
        check("pwm cleared one edge into reset", int'(pwm), 0);
        reset_sequence("mid");
        v = '{3'b001, 3'b000, -1, 2'd0, 0, CENTER, 0, 0};
        run_frame(100, v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
